// File: rtl/imm_chunk_encoder.sv
// Immediate chunk encoder: splits a signed constant into the shortest
// MS-first sequence of signed chunks that a shift-or receiver rebuilds exactly.
//
// state | meaning
// IDLE  | no word in flight, in_ready=1
// SEND  | presenting chunks of the latched word, out_valid=1
module imm_chunk_encoder #(
   parameter int DATA_W  = 16,
   parameter int CHUNK_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CHUNK_W-1:0] out_chunk,
   output logic               out_first,
   output logic               out_last,
   output logic [2:0]         out_count
);

   localparam int NCHUNK = DATA_W / CHUNK_W;

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state, state_nxt;
   logic [DATA_W-1:0]  shreg, shreg_nxt;
   logic [2:0]         rem, rem_nxt;
   logic               first_q, first_nxt;
   logic [2:0]         count_q, count_nxt;
   logic [2:0]         n_calc;
   logic signed [DATA_W-1:0] sx;
   logic               accept, advance;

   // minimal chunk count: smallest n whose bits above the chunk field's sign bit are all equal
   always_comb begin
      n_calc = 3'(NCHUNK);
      sx     = '0;
      for (int n = NCHUNK - 1; n >= 1; n--) begin
         sx = $signed(in_data) >>> (CHUNK_W * n - 1);
         if ((sx == '0) || (&sx)) n_calc = 3'(n);
      end
   end

   assign out_valid = (state == SEND);
   assign out_last  = (state == SEND) && (rem == 3'd0);
   assign out_first = first_q;
   assign out_count = count_q;
   // the word is left-aligned on load so the current chunk is always the top field
   assign out_chunk = shreg[DATA_W-1 -: CHUNK_W];

   assign advance  = out_valid & out_ready;
   assign in_ready = (state == IDLE) | (advance & out_last);
   assign accept   = in_valid & in_ready;

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         rem     <= '0;
         first_q <= 1'b0;
         count_q <= '0;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         rem     <= rem_nxt;
         first_q <= first_nxt;
         count_q <= count_nxt;
      end
   end

   // next-state: a new acceptance wins over draining, giving bubble-free back-to-back words
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      rem_nxt   = rem;
      first_nxt = first_q;
      count_nxt = count_q;
      if (accept) begin
         state_nxt = SEND;
         shreg_nxt = in_data << (CHUNK_W * (NCHUNK - int'(n_calc)));
         rem_nxt   = n_calc - 3'd1;
         first_nxt = 1'b1;
         count_nxt = n_calc;
      end else if (advance) begin
         if (out_last) begin
            state_nxt = IDLE;
            shreg_nxt = '0;
            rem_nxt   = '0;
            first_nxt = 1'b0;
            count_nxt = '0;
         end else begin
            shreg_nxt = shreg << CHUNK_W;
            rem_nxt   = rem - 3'd1;
            first_nxt = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imm_chunk_encoder.sv
// Directed and random checks for imm_chunk_encoder.
module tb_imm_chunk_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [3:0]  out_chunk;
   logic        out_first;
   logic        out_last;
   logic [2:0]  out_count;

   int n_cmp = 0;
   int n_err = 0;

   imm_chunk_encoder dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_chunk(out_chunk),
      .out_first(out_first), .out_last(out_last), .out_count(out_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {valid, first, last, count, chunk}
   task automatic chk_out(input string tag, input logic [3:0] c, input logic f,
                          input logic l, input logic [2:0] n);
      chk(tag, {22'd0, out_valid, out_first, out_last, out_count, out_chunk},
               {22'd0, 1'b1, f, l, n, c});
   endtask

   task automatic chk_idle(input string tag);
      chk(tag, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
   endtask

   // advance one cycle; inputs change and outputs are sampled at the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // present a word from IDLE; it is taken on the next rising edge
   task automatic put(input logic [15:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
   endtask

   function automatic int min_n(input logic [15:0] v);
      int s;
      s = int'($signed(v));
      for (int n = 1; n <= 4; n++)
         if (s >= -(1 << (4*n-1)) && s < (1 << (4*n-1))) return n;
      return 4;
   endfunction

   initial begin
      logic [15:0] r;
      int          acc;
      int          idx;
      int          budget;
      bit          done;

      #1 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_outs", {out_valid, out_first, out_last, out_count, out_chunk}, 10'd0);
      chk_idle("reset_ready");
      @(negedge clk);

      put(16'h0003);
      chk_out("w0003_c0", 4'h3, 1, 1, 3'd1);
      step();
      chk_idle("w0003_idle");

      put(16'hFFF9);
      chk_out("wfff9_c0", 4'h9, 1, 1, 3'd1);
      step();

      put(16'h0008);
      chk_out("w0008_c0", 4'h0, 1, 0, 3'd2);
      step();
      chk_out("w0008_c1", 4'h8, 0, 1, 3'd2);
      step();

      put(16'hFF80);
      chk_out("wff80_c0", 4'h8, 1, 0, 3'd2);
      step();
      chk_out("wff80_c1", 4'h0, 0, 1, 3'd2);
      step();

      put(16'hFFF8);
      chk_out("wfff8_c0", 4'h8, 1, 1, 3'd1);
      step();
      put(16'h0000);
      chk_out("w0000_c0", 4'h0, 1, 1, 3'd1);
      step();

      put(16'h1234);
      chk_out("w1234_c0", 4'h1, 1, 0, 3'd4);
      step();
      chk_out("w1234_c1", 4'h2, 0, 0, 3'd4);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("w1234_stall", 4'h2, 0, 0, 3'd4);
      end
      out_ready = 1'b1;
      step();
      chk_out("w1234_c2", 4'h3, 0, 0, 3'd4);
      step();
      chk_out("w1234_c3", 4'h4, 0, 1, 3'd4);
      step();
      chk_idle("w1234_idle");

      // back-to-back 0x8000 then 0x0000
      in_valid = 1'b1;
      in_data  = 16'h8000;
      step();
      chk_out("b2b_c0", 4'h8, 1, 0, 3'd4);
      in_data = 16'h0000;
      #1 chk("b2b_rdy0", {31'd0, in_ready}, 32'd0);
      step();
      chk_out("b2b_c1", 4'h0, 0, 0, 3'd4);
      step();
      chk_out("b2b_c2", 4'h0, 0, 0, 3'd4);
      step();
      chk_out("b2b_c3", 4'h0, 0, 1, 3'd4);
      #1 chk("b2b_rdy1", {31'd0, in_ready}, 32'd1);
      step();
      chk_out("b2b_w2", 4'h0, 1, 1, 3'd1);
      in_valid = 1'b0;
      step();
      chk_idle("b2b_idle");

      // async reset mid-word
      put(16'h1234);
      step();
      chk_out("rst_pre", 4'h2, 0, 0, 3'd4);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", {out_valid, out_first, out_last, out_count, out_chunk}, 10'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk_idle("rst_release");
      @(negedge clk);
      chk_idle("rst_no_resume");

      // random words with random backpressure, rebuilt by a shift-or decoder
      for (int w = 0; w < 60; w++) begin
         r = (w == 0) ? 16'h7FFF : (w == 1) ? 16'hF7FF : 16'($urandom);
         if (w > 40) r = 16'($signed(16'($urandom_range(0, 255))) - 16'sd128);
         put(r);
         acc = 0; idx = 0; done = 1'b0; budget = 200;
         while (!done && budget > 0) begin
            budget--;
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
               if (idx == 0) begin
                  acc = int'($signed(out_chunk));
                  chk("rnd_first", {29'd0, out_first, out_count},
                                   {29'd0, 1'b1, 3'(min_n(r))});
               end else begin
                  acc = (acc << 4) | int'(out_chunk);
               end
               idx++;
               if (out_last) done = 1'b1;
            end
            step();
         end
         if (!done) chk("rnd_timeout", 32'd0, 32'd1);
         chk("rnd_value", {16'd0, acc[15:0]}, {16'd0, r});
         chk("rnd_nchunk", idx, min_n(r));
         out_ready = 1'b1;
         chk_idle("rnd_idle");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
